// File: rtl/mem_access_pkg.sv
// Shared constants for the MEM stage: RV32I load/store funct3 encodings,
// FSM state encoding and register-file widths.
package mem_access_pkg;

  localparam int unsigned RegAddrLen = 5;
  localparam int unsigned RegLen     = 32;

  localparam logic ResetEnable = 1'b1;
  localparam logic WriteEnable = 1'b1;

  localparam logic [RegLen-1:0] ZERO_WORD = '0;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // Transfer length in bytes from the size field; 0 marks an illegal size.
  function automatic logic [2:0] byte_count(input logic [2:0] funct3);
    logic [2:0] n;
    case (funct3[1:0])
      F3_SB[1:0]: n = 3'd1;
      F3_SH[1:0]: n = 3'd2;
      F3_SW[1:0]: n = 3'd4;
      default:    n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Sign/zero extension of the assembled load buffer according to funct3.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [2:0]        i_funct3,
  input  logic [RegLen-1:0] i_buf,
  output logic [RegLen-1:0] o_word_c
);

  always_comb begin
    o_word_c = i_buf;
    case (i_funct3)
      F3_LB:   o_word_c = {{(RegLen-8){i_buf[7]}}, i_buf[7:0]};
      F3_LH:   o_word_c = {{(RegLen-16){i_buf[15]}}, i_buf[15:0]};
      F3_LBU:  o_word_c = {{(RegLen-8){1'b0}}, i_buf[7:0]};
      F3_LHU:  o_word_c = {{(RegLen-16){1'b0}}, i_buf[15:0]};
      F3_LW:   o_word_c = i_buf;
      default: o_word_c = i_buf;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: byte-serial load/store over an 8-bit memory port,
// combinational pass-through for non-memory instructions.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_rd_we,
  input  logic [RegAddrLen-1:0] in_rd_addr,
  input  logic [RegLen-1:0]     in_alu_result,
  input  logic [3:0]            in_mem_op,
  input  logic                  in_is_store,
  input  logic [RegLen-1:0]     in_store_data,
  output logic                  wb_we,
  output logic [RegAddrLen-1:0] wb_addr,
  output logic [RegLen-1:0]     wb_data,
  output logic                  stall_req,
  output logic                  mc_req,
  output logic                  mc_rw,
  output logic [ADDR_W-1:0]     mc_addr,
  output logic [7:0]            mc_wdata,
  input  logic                  mc_gnt,
  input  logic [7:0]            mc_rdata
);

  localparam int unsigned CntW = 2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_cnt_nxt;
  logic [RegLen-1:0] r_buf;

  logic              w_is_mem;
  logic [2:0]        w_funct3;
  logic [2:0]        w_nbytes;
  logic              w_mem_go;
  logic              w_busy;
  logic              w_last;
  logic              w_capture;
  logic [ADDR_W-1:0] w_byte_addr;
  logic [7:0]        w_store_byte;
  logic [RegLen-1:0] w_load_word;

  assign w_is_mem     = in_mem_op[3];
  assign w_funct3     = in_mem_op[2:0];
  assign w_nbytes     = byte_count(w_funct3);
  assign w_mem_go     = in_valid & w_is_mem & (w_nbytes != 3'd0);
  assign w_last       = ({1'b0, r_cnt} == (w_nbytes - 3'd1));
  assign w_byte_addr  = ADDR_W'(in_alu_result) + ADDR_W'(r_cnt);
  assign w_store_byte = 8'(in_store_data >> {r_cnt, 3'b000});

  // The first byte is offered in IDLE already, so IDLE-with-op behaves like ACCESS.
  assign w_busy = ((r_state == S_IDLE) & w_mem_go) | (r_state == S_ACCESS);

  load_extend u_load_extend (
    .i_funct3 (w_funct3),
    .i_buf    (r_buf),
    .o_word_c (w_load_word)
  );

  always_ff @(posedge clk) begin
    if (rst == ResetEnable) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_buf   <= ZERO_WORD;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_buf[{r_cnt, 3'b000} +: 8] <= mc_rdata;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    wb_we       = 1'b0;
    wb_addr     = '0;
    wb_data     = ZERO_WORD;
    stall_req   = 1'b0;
    mc_req      = 1'b0;
    mc_rw       = 1'b0;
    mc_addr     = '0;
    mc_wdata    = '0;

    if (w_busy) begin
      stall_req   = 1'b1;
      mc_req      = 1'b1;
      mc_rw       = in_is_store;
      mc_addr     = w_byte_addr;
      mc_wdata    = w_store_byte;
      w_state_nxt = S_ACCESS;
      if (mc_gnt) begin
        w_capture = ~in_is_store;
        w_cnt_nxt = r_cnt + CntW'(1);
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
    end else if (r_state == S_DONE) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      wb_addr     = in_rd_addr;
      if (!in_is_store) begin
        wb_we   = in_valid & (in_rd_we == WriteEnable);
        wb_data = w_load_word;
      end
    end else begin
      w_state_nxt = S_IDLE;
      if (in_valid) begin
        wb_we   = ~w_is_mem & (in_rd_we == WriteEnable);
        wb_addr = in_rd_addr;
        wb_data = in_alu_result;
      end
    end

    // Keep every output quiet while reset is held.
    if (rst == ResetEnable) begin
      wb_we     = 1'b0;
      wb_addr   = '0;
      wb_data   = ZERO_WORD;
      stall_req = 1'b0;
      mc_req    = 1'b0;
      mc_rw     = 1'b0;
      mc_addr   = '0;
      mc_wdata  = '0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus random ops
// checked against a byte-addressed memory model.
module tb_mem_access;

  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_rd_we;
  logic [4:0]        in_rd_addr;
  logic [31:0]       in_alu_result;
  logic [3:0]        in_mem_op;
  logic              in_is_store;
  logic [31:0]       in_store_data;
  logic              wb_we;
  logic [4:0]        wb_addr;
  logic [31:0]       wb_data;
  logic              stall_req;
  logic              mc_req;
  logic              mc_rw;
  logic [ADDR_W-1:0] mc_addr;
  logic [7:0]        mc_wdata;
  logic              mc_gnt;
  logic [7:0]        mc_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [logic [31:0]];

  mem_access #(.ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_rd_we      (in_rd_we),
    .in_rd_addr    (in_rd_addr),
    .in_alu_result (in_alu_result),
    .in_mem_op     (in_mem_op),
    .in_is_store   (in_is_store),
    .in_store_data (in_store_data),
    .wb_we         (wb_we),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .stall_req     (stall_req),
    .mc_req        (mc_req),
    .mc_rw         (mc_rw),
    .mc_addr       (mc_addr),
    .mc_wdata      (mc_wdata),
    .mc_gnt        (mc_gnt),
    .mc_rdata      (mc_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] rd_mem(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check(tag, {31'b0, wb_we}, 32'd0);
    check(tag, {27'b0, wb_addr}, 32'd0);
    check(tag, wb_data, 32'd0);
    check(tag, {31'b0, stall_req}, 32'd0);
    check(tag, {31'b0, mc_req}, 32'd0);
    check(tag, {31'b0, mc_rw}, 32'd0);
    check(tag, mc_addr, 32'd0);
    check(tag, {24'b0, mc_wdata}, 32'd0);
  endtask

  // Runs one instruction from just after a posedge until it retires.
  // waits < 0: random grants; otherwise grant after 'waits' idle cycles.
  task automatic run_op(input logic v, input logic we, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [3:0] op,
                        input logic st, input logic [31:0] sd,
                        input int waits, output logic [31:0] got_data);
    int          n;
    int          granted;
    int          waited;
    int          cycles;
    bit          done;
    bit          gnt;
    logic [31:0] a;
    logic [31:0] val;
    logic [31:0] exp_load;
    logic [7:0]  exp_byte;

    in_valid      = v;
    in_rd_we      = we;
    in_rd_addr    = rd;
    in_alu_result = alu;
    in_mem_op     = op;
    in_is_store   = st;
    in_store_data = sd;
    mc_gnt        = 1'b0;
    got_data      = '0;
    n = (op[1:0] == 2'b11) ? 0 : (1 << op[1:0]);

    if (!v || !op[3] || n == 0) begin
      @(negedge clk);
      check("pass_we", {31'b0, wb_we}, {31'b0, (v && !op[3] && we)});
      check("pass_stall", {31'b0, stall_req}, 32'd0);
      check("pass_mcreq", {31'b0, mc_req}, 32'd0);
      if (v && !op[3]) begin
        check("pass_addr", {27'b0, wb_addr}, {27'b0, rd});
        check("pass_data", wb_data, alu);
      end
      got_data = wb_data;
      @(posedge clk); #1;
      return;
    end

    val = '0;
    if (!st) begin
      for (int i = 0; i < n; i++) val = val | (32'(rd_mem(alu + 32'(i))) << (8 * i));
    end
    case (op[2:0])
      3'b000:  exp_load = int'($signed(val[7:0]));
      3'b001:  exp_load = int'($signed(val[15:0]));
      3'b100:  exp_load = 32'(val[7:0]);
      3'b101:  exp_load = 32'(val[15:0]);
      default: exp_load = val;
    endcase

    granted = 0;
    waited  = 0;
    cycles  = 0;
    done    = 1'b0;
    while (!done) begin
      @(negedge clk);
      cycles++;
      if (cycles > 200) begin
        checks++;
        errors++;
        $display("FAIL timeout: op %h granted %0d of %0d bytes", op, granted, n);
        done = 1'b1;
      end else if (granted < n) begin
        a        = alu + 32'(granted);
        exp_byte = 8'(sd >> (8 * granted));
        check("acc_stall", {31'b0, stall_req}, 32'd1);
        check("acc_req", {31'b0, mc_req}, 32'd1);
        check("acc_rw", {31'b0, mc_rw}, {31'b0, st});
        check("acc_addr", mc_addr, a);
        check("acc_we", {31'b0, wb_we}, 32'd0);
        if (st) check("acc_wdata", {24'b0, mc_wdata}, {24'b0, exp_byte});
        gnt = (waits < 0) ? ($urandom_range(0, 1) == 1) : (waited >= waits);
        if (gnt) begin
          mc_gnt = 1'b1;
          waited = 0;
          if (st) mem[a] = exp_byte;
          else    mc_rdata = rd_mem(a);
          granted++;
        end else begin
          mc_gnt   = 1'b0;
          mc_rdata = 8'($urandom);
          waited++;
        end
      end else begin
        mc_gnt = 1'b0;
        check("done_stall", {31'b0, stall_req}, 32'd0);
        check("done_req", {31'b0, mc_req}, 32'd0);
        check("done_we", {31'b0, wb_we}, {31'b0, (!st && we)});
        if (!st) begin
          check("done_addr", {27'b0, wb_addr}, {27'b0, rd});
          check("done_data", wb_data, exp_load);
        end
        got_data = wb_data;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    mc_gnt = 1'b0;
  endtask

  logic [31:0] d;
  logic [2:0]  load_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd_we = 1'b0; in_rd_addr = '0;
    in_alu_result = '0; in_mem_op = '0; in_is_store = 1'b0; in_store_data = '0;
    mc_gnt = 1'b0; mc_rdata = '0;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_quiet("rst_held");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_quiet("rst_idle");
    @(posedge clk); #1;

    // ALU pass-through
    run_op(1'b1, 1'b1, 5'd5, 32'h1234_5678, 4'b0010, 1'b0, 32'h0, 0, d);
    check("add_data", d, 32'h1234_5678);

    // LW with grant always high
    mem[32'h1000] = 8'h78; mem[32'h1001] = 8'h56;
    mem[32'h1002] = 8'h34; mem[32'h1003] = 8'h12;
    run_op(1'b1, 1'b1, 5'd7, 32'h1000, 4'b1010, 1'b0, 32'h0, 0, d);
    check("lw_data", d, 32'h1234_5678);

    // LB / LBU / misaligned LH
    mem[32'h2003] = 8'h80;
    run_op(1'b1, 1'b1, 5'd8, 32'h2003, 4'b1000, 1'b0, 32'h0, 0, d);
    check("lb_data", d, 32'hFFFF_FF80);
    run_op(1'b1, 1'b1, 5'd8, 32'h2003, 4'b1100, 1'b0, 32'h0, 0, d);
    check("lbu_data", d, 32'h0000_0080);
    mem[32'h2001] = 8'hFE; mem[32'h2002] = 8'hFF;
    run_op(1'b1, 1'b1, 5'd9, 32'h2001, 4'b1001, 1'b0, 32'h0, 0, d);
    check("lh_data", d, 32'hFFFF_FFFE);

    // SH with two wait cycles before each grant
    run_op(1'b1, 1'b1, 5'd3, 32'h3000, 4'b1001, 1'b1, 32'hAABB_CCDD, 2, d);

    // Reset during the third byte of an LW
    in_valid = 1'b1; in_rd_we = 1'b1; in_rd_addr = 5'd7; in_alu_result = 32'h1000;
    in_mem_op = 4'b1010; in_is_store = 1'b0; in_store_data = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rstmid_addr", mc_addr, 32'h1000 + 32'(i));
      mc_gnt = 1'b1;
      mc_rdata = mem[32'h1000 + 32'(i)];
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("rstmid_addr", mc_addr, 32'h1002);
    mc_gnt = 1'b1;
    mc_rdata = mem[32'h1002];
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    mc_gnt = 1'b0;
    @(negedge clk);
    check_quiet("rstmid_quiet");
    @(posedge clk); #1;
    run_op(1'b1, 1'b1, 5'd7, 32'h1000, 4'b1010, 1'b0, 32'h0, 0, d);
    check("lw_after_rst", d, 32'h1234_5678);

    // SW across the address wrap, then back-to-back LW of the same word
    run_op(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFE, 4'b1010, 1'b1, 32'h1122_3344, 0, d);
    run_op(1'b1, 1'b1, 5'd11, 32'hFFFF_FFFE, 4'b1010, 1'b0, 32'h0, 0, d);
    check("wrap_lw", d, 32'h1122_3344);

    // Random mix of ALU ops, loads, stores, illegal sizes and bubbles
    for (int k = 0; k < 200; k++) begin
      logic        v;
      logic        st;
      logic [3:0]  op;
      logic [31:0] a;
      int          kind;
      int          w;
      v    = ($urandom_range(0, 9) != 0);
      kind = $urandom_range(0, 9);
      st   = 1'b0;
      if (kind <= 2) begin
        op = {1'b0, 3'($urandom)};
        st = 1'($urandom);
      end else if (kind <= 5) begin
        op = {1'b1, load_f3[$urandom_range(0, 4)]};
      end else if (kind <= 8) begin
        op = {1'b1, 1'b0, 2'($urandom_range(0, 2))};
        st = 1'b1;
      end else begin
        op = {1'b1, 1'($urandom), 2'b11};
        st = 1'($urandom);
      end
      a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                      : (32'h4000 + 32'($urandom_range(0, 63)));
      w = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 2);
      run_op(v, 1'($urandom), 5'($urandom), a, op, st, $urandom, w, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
